dual_port_mem_responder: RTL and testbench

- Responder-side memory for the existing stimulus generator's write/read protocol.
- Accepts byte writes on one address, reads on a separate address, and returns read data on one of two output ports, A or B, selected by Readtoa/Readtob.
- On reset, runs a self-clearing sweep before accepting traffic.
- Sits between the stimulus generator and the checker/monitor in the memory testbench tier.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_array_1w1r.sv | 41 ++++
 rtl/dual_port_mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_dual_port_mem_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared constants, FSM state encoding and parity helper for the
//               dual-port memory responder.
//               Optional feature macro: PARITY_CHECK_EN (see top level).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

   localparam int MEM_DATA_W = 8;
   localparam int MEM_ADDR_W = 10;
   localparam int MEM_DEPTH  = 1024;   // always 2**MEM_ADDR_W

   typedef enum logic [0:0] {
      INIT = 1'b0,   // clearing sweep, all traffic ignored
      RUN  = 1'b1    // accepting writes and reads
   } state_t;

   // Even parity: the returned bit makes the total count of ones even.
   // An all-zero word therefore carries parity 0, which lets the clearing
   // sweep simply write zeros across the whole stored word.
   function automatic logic even_parity(input logic [MEM_DATA_W-1:0] d);
      return ^d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array_1w1r.sv
`default_nettype none
// ============================================================================
// Module      : mem_array_1w1r
// Description : Plain storage array, one synchronous write port and one
//               combinational (asynchronous) read port. No reset: contents
//               are initialised by the owner's clearing sweep.
// Ports       : clk   - write clock, rising edge
//               we    - write enable
//               waddr - write address
//               wdata - write data
//               raddr - read address
//               rdata - read data, combinational from raddr
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array_1w1r
   import mem_pkg::*;
#(
   parameter int WIDTH  = MEM_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DEPTH  = MEM_DEPTH
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/dual_port_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_mem_responder
// Description : Responder memory for the stimulus generator's write/read
//               protocol. After reset a clearing sweep zeroes every word
//               (DEPTH cycles), then byte writes and 1-cycle-latency reads are
//               served. Read results are routed to port A or port B; a
//               request on both ports at once is a conflict and reads nothing.
//               Same-cycle read/write of one address returns the new data.
// Option      : `define PARITY_CHECK_EN to store an even-parity bit per word
//               and flag read-side parity errors on oParityErr.
// Ports       : clk          - clock, rising edge
//               iReset_n     - asynchronous active-low reset
//               validdata    - write data
//               iWriteEnable - write strobe
//               iAddress     - write address
//               iReadAddress - read address
//               Readtoa      - read request routed to port A
//               Readtob      - read request routed to port B
//               oReady       - sweep finished, traffic accepted
//               oDataA/B     - read data, held until next read on that port
//               oValidA/B    - one-cycle strobe, port data updated
//               oParityErr   - (option) parity mismatch, aligned with valid
//               oConflict    - one-cycle strobe, both read requests high
// Revision    : 1.0 - initial release
// ============================================================================
module dual_port_mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DEPTH  = MEM_DEPTH     // must equal 2**ADDR_W
) (
   input  logic              clk,
   input  logic              iReset_n,
   input  logic [DATA_W-1:0] validdata,
   input  logic              iWriteEnable,
   input  logic [ADDR_W-1:0] iAddress,
   input  logic [ADDR_W-1:0] iReadAddress,
   input  logic              Readtoa,
   input  logic              Readtob,
   output logic              oReady,
   output logic [DATA_W-1:0] oDataA,
   output logic              oValidA,
   output logic [DATA_W-1:0] oDataB,
   output logic              oValidB,
`ifdef PARITY_CHECK_EN
   output logic              oParityErr,
`endif
   output logic              oConflict
);

`ifdef PARITY_CHECK_EN
   localparam int MEM_W = DATA_W + 1;   // parity bit kept in the MSB
`else
   localparam int MEM_W = DATA_W;
`endif

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   clr_ptr;
   logic [ADDR_W-1:0]   clr_ptr_nxt;

   // Memory port controls
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [MEM_W-1:0]    mem_wdata;
   logic [MEM_W-1:0]    mem_rdata;
   logic [MEM_W-1:0]    wr_word;

   // Read routing
   logic                rd_a;
   logic                rd_b;
   logic                rd_both;
   logic                bypass;
   logic [DATA_W-1:0]   rd_word;

`ifdef PARITY_CHECK_EN
   logic                rd_perr;
   assign wr_word = {even_parity(validdata), validdata};
`else
   assign wr_word = validdata;
`endif

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge iReset_n) begin
      if (!iReset_n) begin
         state   <= INIT;
         clr_ptr <= '0;
      end else begin
         state   <= state_nxt;
         clr_ptr <= clr_ptr_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state, sweep muxing and request decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      mem_we      = 1'b0;
      mem_waddr   = iAddress;
      mem_wdata   = wr_word;
      rd_a        = 1'b0;
      rd_b        = 1'b0;
      rd_both     = 1'b0;

      case (state)
         INIT: begin
            // The sweep owns the write port; external traffic is dropped.
            mem_we      = 1'b1;
            mem_waddr   = clr_ptr;
            mem_wdata   = '0;
            clr_ptr_nxt = clr_ptr + ADDR_W'(1);
            if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
               state_nxt   = RUN;
               clr_ptr_nxt = '0;
            end
         end
         RUN: begin
            mem_we  = iWriteEnable;
            rd_a    = Readtoa & ~Readtob;
            rd_b    = Readtob & ~Readtoa;
            rd_both = Readtoa &  Readtob;
         end
         default: begin
            state_nxt = INIT;
         end
      endcase
   end

   assign oReady = (state == RUN);

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   mem_array_1w1r #(
      .WIDTH  (MEM_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk    (clk),
      .we     (mem_we),
      .waddr  (mem_waddr),
      .wdata  (mem_wdata),
      .raddr  (iReadAddress),
      .rdata  (mem_rdata)
   );

   // Write-first: a same-cycle write to the read address forwards the new
   // data, since the array only updates at the clock edge.
   assign bypass  = iWriteEnable && (iAddress == iReadAddress);
   assign rd_word = bypass ? validdata : mem_rdata[DATA_W-1:0];

`ifdef PARITY_CHECK_EN
   // Forwarded data never went through storage, so it cannot be corrupt.
   assign rd_perr = bypass ? 1'b0
                           : (even_parity(mem_rdata[DATA_W-1:0]) != mem_rdata[DATA_W]);
`endif

   // ------------------------------------------------------------------------
   // Output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge iReset_n) begin
      if (!iReset_n) begin
         oDataA     <= '0;
         oDataB     <= '0;
         oValidA    <= 1'b0;
         oValidB    <= 1'b0;
         oConflict  <= 1'b0;
`ifdef PARITY_CHECK_EN
         oParityErr <= 1'b0;
`endif
      end else begin
         oValidA    <= rd_a;
         oValidB    <= rd_b;
         oConflict  <= rd_both;
         if (rd_a) begin
            oDataA <= rd_word;
         end
         if (rd_b) begin
            oDataB <= rd_word;
         end
`ifdef PARITY_CHECK_EN
         oParityErr <= (rd_a | rd_b) & rd_perr;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dual_port_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_port_mem_responder
// Description : Directed self-checking bench for dual_port_mem_responder.
//               Build with +define+PARITY_CHECK_EN to also cover the parity
//               error path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_port_mem_responder;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;
   localparam int INIT_LIMIT = 3000;

   logic              clk = 1'b0;
   logic              iReset_n;
   logic [DATA_W-1:0] validdata;
   logic              iWriteEnable;
   logic [ADDR_W-1:0] iAddress;
   logic [ADDR_W-1:0] iReadAddress;
   logic              Readtoa;
   logic              Readtob;
   logic              oReady;
   logic [DATA_W-1:0] oDataA;
   logic              oValidA;
   logic [DATA_W-1:0] oDataB;
   logic              oValidB;
   logic              oConflict;
`ifdef PARITY_CHECK_EN
   logic              oParityErr;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dual_port_mem_responder #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk          (clk),
      .iReset_n     (iReset_n),
      .validdata    (validdata),
      .iWriteEnable (iWriteEnable),
      .iAddress     (iAddress),
      .iReadAddress (iReadAddress),
      .Readtoa      (Readtoa),
      .Readtob      (Readtob),
      .oReady       (oReady),
      .oDataA       (oDataA),
      .oValidA      (oValidA),
      .oDataB       (oDataB),
      .oValidB      (oValidB),
`ifdef PARITY_CHECK_EN
      .oParityErr   (oParityErr),
`endif
      .oConflict    (oConflict)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; outputs are stable 1 ns after the edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iWriteEnable = 1'b0;
      Readtoa      = 1'b0;
      Readtob      = 1'b0;
   endtask

   task automatic drive(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                        input logic ra, input logic rb, input logic [ADDR_W-1:0] rd_addr);
      iWriteEnable = we;
      iAddress     = wa;
      validdata    = wd;
      Readtoa      = ra;
      Readtob      = rb;
      iReadAddress = rd_addr;
   endtask

   // Count edges from reset release until oReady; any strobe seen meanwhile
   // is an error because INIT must ignore all inputs.
   task automatic wait_ready(input string tag);
      int  n;
      logic stray;
      n     = 0;
      stray = 1'b0;
      while (!oReady && n < INIT_LIMIT) begin
         cycle();
         n++;
         if (!oReady) stray = stray | oValidA | oValidB | oConflict;
      end
      check({tag, "_len"}, n, DEPTH);
      check({tag, "_quiet"}, {31'd0, stray}, 32'd0);
   endtask

   initial begin
      iReset_n = 1'b0;
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
      repeat (3) cycle();

      // Reset values
      check("rst_ready", {31'd0, oReady}, 0);
      check("rst_outs", {oDataA, oDataB, 5'd0, oValidA, oValidB, oConflict}, 0);

      // Release with traffic active; INIT must drop all of it.
      drive(1'b1, 10'd7, 8'hAA, 1'b1, 1'b0, 10'd7);
      iReset_n = 1'b1;
      wait_ready("init1");
      idle();

      // Read of cleared word
      drive(1'b0, '0, '0, 1'b1, 1'b0, 10'd5);
      cycle();
      check("rd5_data", oDataA, 0);
      check("rd5_va", {31'd0, oValidA}, 1);
      idle();
      cycle();
      check("rd5_va_drop", {31'd0, oValidA}, 0);

      // Write 8 @0, read to A
      drive(1'b1, 10'd0, 8'd8, 1'b0, 1'b0, '0);
      cycle();
      drive(1'b0, '0, '0, 1'b1, 1'b0, 10'd0);
      cycle();
      check("rd0_a", oDataA, 8);
      check("rd0_strobes", {30'd0, oValidA, oValidB}, 2'b10);

      // Write 16 @10, read to B
      drive(1'b1, 10'd10, 8'd16, 1'b0, 1'b0, '0);
      cycle();
      drive(1'b0, '0, '0, 1'b0, 1'b1, 10'd10);
      cycle();
      check("rd10_b", oDataB, 16);
      check("rd10_a_hold", oDataA, 8);
      check("rd10_strobes", {30'd0, oValidA, oValidB}, 2'b01);

      // Write-first at top address
      drive(1'b1, 10'd1023, 8'd64, 1'b1, 1'b0, 10'd1023);
      cycle();
      check("wf1023_a", oDataA, 64);

      // Write 32 @31, read to B
      drive(1'b1, 10'd31, 8'd32, 1'b0, 1'b0, '0);
      cycle();
      drive(1'b0, '0, '0, 1'b0, 1'b1, 10'd31);
      cycle();
      check("rd31_b", oDataB, 32);

      // Conflict with concurrent write of 99 @12
      drive(1'b1, 10'd12, 8'd99, 1'b1, 1'b1, 10'd10);
      cycle();
      check("cfl_strobe", {29'd0, oConflict, oValidA, oValidB}, 3'b100);
      check("cfl_hold", {16'd0, oDataA, oDataB}, {16'd0, 8'd64, 8'd32});
      idle();
      cycle();
      check("cfl_drop", {31'd0, oConflict}, 0);
      drive(1'b0, '0, '0, 1'b0, 1'b1, 10'd12);
      cycle();
      check("rd12_b", oDataB, 99);

      // Held Readtoa: one strobe per cycle, address followed
      drive(1'b0, '0, '0, 1'b1, 1'b0, 10'd0);
      cycle();
      check("held0", {23'd0, oValidA, oDataA}, {23'd0, 1'b1, 8'd8});
      iReadAddress = 10'd10;
      cycle();
      check("held1", {23'd0, oValidA, oDataA}, {23'd0, 1'b1, 8'd16});
      iReadAddress = 10'd7;   // INIT-time write of 0xAA must not have landed
      cycle();
      check("held2_init_ignored", {23'd0, oValidA, oDataA}, {23'd0, 1'b1, 8'd0});
      idle();

`ifdef PARITY_CHECK_EN
      drive(1'b1, 10'd3, 8'h55, 1'b0, 1'b0, '0);
      cycle();
      drive(1'b0, '0, '0, 1'b1, 1'b0, 10'd3);
      cycle();
      check("par_clean", {30'd0, oValidA, oParityErr}, 2'b10);
      idle();
      dut.u_mem.mem[3] = dut.u_mem.mem[3] ^ 9'h001;
      cycle();
      drive(1'b0, '0, '0, 1'b1, 1'b0, 10'd3);
      cycle();
      check("par_err", {30'd0, oValidA, oParityErr}, 2'b11);
      drive(1'b0, '0, '0, 1'b1, 1'b0, 10'd0);
      cycle();
      check("par_other", {30'd0, oValidA, oParityErr}, 2'b10);
      idle();
`endif

      // Reset mid-run: asynchronous clear of outputs
      cycle();
      iReset_n = 1'b0;
      #1;
      check("mid_rst_outs", {oDataA, oDataB, 4'd0, oReady, oValidA, oValidB, oConflict}, 0);
      cycle();
      iReset_n = 1'b1;
      // Reset again partway through the sweep; it must restart from zero.
      repeat (500) cycle();
      check("mid_init_ready", {31'd0, oReady}, 0);
      iReset_n = 1'b0;
      cycle();
      iReset_n = 1'b1;
      wait_ready("init2");

      drive(1'b0, '0, '0, 1'b1, 1'b0, 10'd0);
      cycle();
      check("post_rst_rd0", {23'd0, oValidA, oDataA}, {23'd0, 1'b1, 8'd0});
      drive(1'b0, '0, '0, 1'b0, 1'b1, 10'd1023);
      cycle();
      check("post_rst_rd1023", {23'd0, oValidB, oDataB}, {23'd0, 1'b1, 8'd0});
      idle();
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
